hamming_rx_ctrl: RTL and testbench

HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

---
 rtl/hamming_rx_ctrl_pkg.sv | 27 ++
 rtl/hamming_dec12.sv | 28 ++
 rtl/hamming_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_rx_ctrl_pkg.sv
// Shared definitions for the Hamming(12,8) receive controller.
//   - FSM state encoding
//   - codeword/data widths and the syndrome range that marks a codeword uncorrectable
//   - syn_is_bad(): true when a syndrome falls in the uncorrectable range
package hamming_rx_ctrl_pkg;

  localparam int CW_W       = 12;
  localparam int DATA_W     = 8;
  localparam int SYN_W      = 4;
  localparam int LEN_W      = 9;   // byte counter must hold 256
  localparam int SYN_BAD_LO = 13;
  localparam int SYN_BAD_HI = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Widened by one bit so the upper bound is a real comparison, not a
  // constant-true one at the syndrome's natural width.
  function automatic logic syn_is_bad(input logic [SYN_W-1:0] syn);
    return ({1'b0, syn} >= 5'(SYN_BAD_LO)) && ({1'b0, syn} <= 5'(SYN_BAD_HI));
  endfunction

endpackage

// File: rtl/hamming_dec12.sv
// Combinational Hamming(12,8) decoder.
//   cw_i       : received codeword, bit i = code position i+1
//   data_o     : payload byte after single-bit correction
//   syndrome_o : raw syndrome (0 clean, 1..12 corrected position, 13..15 uncorrectable)
module hamming_dec12
  import hamming_rx_ctrl_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SYN_W-1:0]  syndrome_o
);

  logic [CW_W-1:0] fixed;

  always_comb begin
    syndrome_o = {^{cw_i[7], cw_i[8], cw_i[9], cw_i[10], cw_i[11]},
                  ^{cw_i[3], cw_i[4], cw_i[5], cw_i[6], cw_i[11]},
                  ^{cw_i[1], cw_i[2], cw_i[5], cw_i[6], cw_i[9], cw_i[10]},
                  ^{cw_i[0], cw_i[2], cw_i[4], cw_i[6], cw_i[8], cw_i[10]}};
    fixed = cw_i;
    // Syndrome value equals the 1-based position of the erroneous bit.
    if ((syndrome_o != '0) && !syn_is_bad(syndrome_o)) begin
      fixed[syndrome_o - SYN_W'(1)] = ~cw_i[syndrome_o - SYN_W'(1)];
    end
    data_o = {fixed[11:8], fixed[6:4], fixed[2]};
  end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Frame-level receive controller for Hamming(12,8) codewords.
// A frame is one header codeword (byte L, N = L or 256 when L = 0) followed by
// N payload codewords. Payload bytes leave through a single registered
// valid/ready stage; per-frame corrected/uncorrectable status is published
// with a one-cycle frame_done pulse. A bad header is dropped with hdr_err.
//   clk, rst_n          : clock, synchronous active-low reset
//   en                  : accept new frames
//   cw_in/valid/ready   : codeword input handshake
//   dout/valid/ready    : corrected byte output handshake, dout_last on final byte
//   frame_done          : status pulse; corr_cnt/uncorr hold the finished frame's status
//   hdr_err             : pulse when a header codeword is uncorrectable
module hamming_rx_ctrl
  import hamming_rx_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CW_W-1:0]   cw_in,
  input  logic              cw_valid,
  output logic              cw_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              frame_done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic              uncorr,
  output logic              hdr_err
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic [CNT_W-1:0]    acc_q, acc_d, acc_inc;
  logic                acc_unc_q, acc_unc_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                dout_last_q, dout_last_d;
  logic                hdr_err_q, hdr_err_d;
  logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
  logic                uncorr_q, uncorr_d;

  logic [DATA_W-1:0]   dec_byte;
  logic [SYN_W-1:0]    dec_syn;
  logic                syn_bad, syn_corr, cw_xfer;

  hamming_dec12 u_dec (
    .cw_i       (cw_in),
    .data_o     (dec_byte),
    .syndrome_o (dec_syn)
  );

  assign syn_bad  = syn_is_bad(dec_syn);
  assign syn_corr = (dec_syn != '0) && !syn_bad;
  assign cw_xfer  = cw_valid && cw_ready;
  assign acc_inc  = (acc_q == '1) ? acc_q : acc_q + CNT_W'(1);  // saturating

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    left_d       = left_q;
    acc_d        = acc_q;
    acc_unc_d    = acc_unc_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    hdr_err_d    = 1'b0;
    corr_cnt_d   = corr_cnt_q;
    uncorr_d     = uncorr_q;
    cw_ready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_HDR;
          acc_d     = '0;
          acc_unc_d = 1'b0;
        end
      end

      ST_HDR: begin
        cw_ready = 1'b1;
        if (cw_xfer) begin
          if (syn_bad) begin
            hdr_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            left_d  = (dec_byte == '0) ? LEN_W'(256) : LEN_W'(dec_byte);
            state_d = ST_DATA;
            if (syn_corr) acc_d = acc_inc;
          end
        end
      end

      ST_DATA: begin
        // Once the final codeword is taken, input stays closed until DONE.
        cw_ready = (left_q != '0) && (!dout_valid_q || dout_ready);
        if (cw_xfer) begin
          dout_d       = dec_byte;
          dout_valid_d = 1'b1;
          dout_last_d  = (left_q == LEN_W'(1));
          left_d       = left_q - LEN_W'(1);
          if (syn_corr) acc_d = acc_inc;
          if (syn_bad)  acc_unc_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            // Publish status on the DONE entry edge so it is visible with frame_done.
            state_d    = ST_DONE;
            corr_cnt_d = acc_q;
            uncorr_d   = acc_unc_q;
          end
        end
      end

      ST_DONE: begin
        if (en) begin
          state_d   = ST_HDR;
          acc_d     = '0;
          acc_unc_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      left_q       <= '0;
      acc_q        <= '0;
      acc_unc_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      hdr_err_q    <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      acc_q        <= acc_d;
      acc_unc_q    <= acc_unc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      hdr_err_q    <= hdr_err_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_q     <= uncorr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign hdr_err    = hdr_err_q;
  assign frame_done = (state_q == ST_DONE);
  assign corr_cnt   = corr_cnt_q;
  assign uncorr     = uncorr_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Self-checking bench for hamming_rx_ctrl. The reference model encodes bytes
// by position-XOR parity and decodes received codewords from first
// principles, producing a queue of expected bytes and per-frame status.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_hamming_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] cw_in;
  logic        cw_valid;
  logic        cw_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        frame_done;
  logic [7:0]  corr_cnt;
  logic        uncorr;
  logic        hdr_err;

  logic        cw_ready2, dout_valid2, dout_last2, frame_done2, uncorr2, hdr_err2;
  logic [7:0]  dout2;
  logic [1:0]  corr_cnt2;

  hamming_rx_ctrl #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cw_in(cw_in), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .frame_done(frame_done),
    .corr_cnt(corr_cnt), .uncorr(uncorr), .hdr_err(hdr_err)
  );

  hamming_rx_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .cw_in(cw_in), .cw_valid(cw_valid),
    .cw_ready(cw_ready2), .dout(dout2), .dout_valid(dout_valid2),
    .dout_ready(dout_ready), .dout_last(dout_last2), .frame_done(frame_done2),
    .corr_cnt(corr_cnt2), .uncorr(uncorr2), .hdr_err(hdr_err2)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit rand_rdy = 1'b0;
  bit drop_en  = 1'b0;

  logic [11:0] frame_q[$];
  logic [8:0]  exp_bytes[$];    // {last, byte}
  int          exp_corr_q[$];
  bit          exp_unc_q[$];
  int          exp_hdr_err = 0;
  int          acc_cyc[$];
  int          xfer_cyc[$];
  logic [7:0]  acc_dout[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  localparam int POS[8] = '{3, 5, 6, 7, 9, 10, 11, 12};  // code position of byte bit i

  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] c = '0;
    int x = 0;
    for (int i = 0; i < 8; i++) if (d[i]) begin c[POS[i]-1] = 1'b1; x ^= POS[i]; end
    for (int k = 0; k < 4; k++) if (x[k]) c[(1 << k) - 1] = 1'b1;
    return c;
  endfunction

  function automatic int syn_of(input logic [11:0] c);
    int x = 0;
    for (int i = 0; i < 12; i++) if (c[i]) x ^= (i + 1);
    return x;
  endfunction

  function automatic logic [7:0] decode(input logic [11:0] c);
    logic [7:0] d;
    int s = syn_of(c);
    if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
    for (int i = 0; i < 8; i++) d[i] = c[POS[i]-1];
    return d;
  endfunction

  task automatic model_frame(output bit hdr_bad, output int corr, output bit unc);
    int s, n;
    logic [7:0] b;
    corr = 0; unc = 1'b0;
    s = syn_of(frame_q[0]);
    hdr_bad = (s >= 13);
    if (hdr_bad) begin
      exp_hdr_err++;
      return;
    end
    if (s != 0) corr++;
    b = decode(frame_q[0]);
    n = (b == 0) ? 256 : int'(b);
    for (int i = 1; i <= n; i++) begin
      s = syn_of(frame_q[i]);
      if (s >= 13) unc = 1'b1;
      else if (s != 0) corr++;
      exp_bytes.push_back({(i == n), decode(frame_q[i])});
    end
    exp_corr_q.push_back(corr);
    exp_unc_q.push_back(unc);
  endtask

  // ---------------- drivers ----------------
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic send_cw(input logic [11:0] c);
    int guard = 0;
    bit done = 1'b0;
    cw_in = c;
    cw_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (cw_ready) begin
        done = 1'b1;
        xfer_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 3000) begin
        check("cw_ready_timeout", 32'(cw_ready), 32'd1);
        done = 1'b1;
      end
    end
    cw_valid = 1'b0;
  endtask

  task automatic run_frame(input bit lit_bad, input int lit_corr, input bit lit_unc);
    bit b, u;
    int c, guard;
    model_frame(b, c, u);
    check("model_hdr_bad", 32'(b), 32'(lit_bad));
    if (!b) begin
      check("model_corr", c, lit_corr);
      check("model_uncorr", 32'(u), 32'(lit_unc));
    end
    foreach (frame_q[i]) begin
      send_cw(frame_q[i]);
      if (i == 0 && drop_en) en = 1'b0;
    end
    guard = 0;
    while ((exp_bytes.size() != 0 || exp_corr_q.size() != 0 || exp_hdr_err != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("frame_timeout", exp_corr_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [8:0] e;
    int ec;
    bit prev_stall = 1'b0;
    logic [7:0] prev_dout = '0;
    logic prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", 32'(dout), 32'(prev_dout));
        check("stall_last", 32'(dout_last), 32'(prev_last));
      end
      if (dout_valid && exp_bytes.size() == 0) begin
        check("unexpected_dout_valid", 32'(dout_valid), 32'd0);
      end else if (dout_valid && dout_ready) begin
        e = exp_bytes.pop_front();
        check("dout", 32'(dout), 32'(e[7:0]));
        check("dout_last", 32'(dout_last), 32'(e[8]));
        acc_cyc.push_back(cyc);
        acc_dout.push_back(dout);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (frame_done) begin
        if (exp_corr_q.size() == 0) begin
          check("unexpected_frame_done", 32'(frame_done), 32'd0);
        end else begin
          ec = exp_corr_q.pop_front();
          check("corr_cnt", 32'(corr_cnt), (ec > 255) ? 255 : ec);
          check("corr_cnt_w2", 32'(corr_cnt2), (ec > 3) ? 3 : ec);
          check("uncorr", 32'(uncorr), 32'(exp_unc_q.pop_front()));
        end
      end
      if (hdr_err) begin
        if (exp_hdr_err == 0) check("unexpected_hdr_err", 32'(hdr_err), 32'd0);
        else begin
          exp_hdr_err--;
          check("hdr_err_no_dout", 32'(dout_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cw_ready"}, 32'(cw_ready), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout_last"}, 32'(dout_last), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_hdr_err"}, 32'(hdr_err), 32'd0);
    check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
    check({tag, "_corr_cnt_w2"}, 32'(corr_cnt2), 32'd0);
    check({tag, "_uncorr"}, 32'(uncorr), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [11:0] c;
    rst_n = 1'b0; en = 1'b0; cw_in = '0; cw_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hand-computed pins for the model.
    check("enc_A5", 32'(enc(8'hA5)), 32'hA27);
    check("enc_03", 32'(enc(8'h03)), 32'h01E);
    check("syn_81C", syn_of(12'h81C), 14);
    check("syn_3C_b5", syn_of(enc(8'h3C) ^ 12'h020), 6);
    check("dec_3C_b5", 32'(decode(enc(8'h3C) ^ 12'h020)), 32'h3C);
    check("dec_801", 32'(decode(12'h801)), 32'h80);

    en = 1'b1;

    // Clean 3-byte frame at full throughput.
    acc_cyc.delete(); xfer_cyc.delete(); acc_dout.delete();
    frame_q = '{enc(8'h03), enc(8'hA5), enc(8'h3C), enc(8'hFF)};
    run_frame(1'b0, 0, 1'b0);
    check("t1_byte0", 32'(acc_dout[0]), 32'hA5);
    check("t1_byte1", 32'(acc_dout[1]), 32'h3C);
    check("t1_byte2", 32'(acc_dout[2]), 32'hFF);
    check("t1_consec_a", acc_cyc[1] - acc_cyc[0], 1);
    check("t1_consec_b", acc_cyc[2] - acc_cyc[1], 1);
    check("t1_latency", acc_cyc[0] - xfer_cyc[1], 1);

    // Single-bit error at code bit 5 of the 0x3C codeword.
    frame_q = '{enc(8'h03), enc(8'hA5), enc(8'h3C) ^ 12'h020, enc(8'hFF)};
    run_frame(1'b0, 1, 1'b0);

    // Uncorrectable header (syndrome 14), then a normal frame as next header.
    frame_q = '{12'h81C};
    run_frame(1'b1, 0, 1'b0);
    frame_q = '{enc(8'h01), enc(8'h5A)};
    run_frame(1'b0, 0, 1'b0);

    // Uncorrectable payload codeword: byte still emitted, frame flagged.
    frame_q = '{enc(8'h02), 12'h801, enc(8'h77)};
    run_frame(1'b0, 0, 1'b1);

    // Six corrections (header + five payloads): saturates the 2-bit counter.
    frame_q = '{enc(8'h05) ^ 12'h800};
    for (int i = 1; i <= 5; i++) begin
      c = enc(8'(i * 16));
      c[2*(i-1)] = ~c[2*(i-1)];
      frame_q.push_back(c);
    end
    run_frame(1'b0, 6, 1'b0);

    // en dropped after the header: frame still completes, then input stays closed.
    drop_en = 1'b1;
    frame_q = '{enc(8'h02), enc(8'h11), enc(8'hEE)};
    run_frame(1'b0, 0, 1'b0);
    drop_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("en_low_cw_ready", 32'(cw_ready), 32'd0);
    end
    @(posedge clk); #1;
    en = 1'b1;

    // 256-byte frame, random backpressure, every 17th codeword with one flipped bit.
    rand_rdy = 1'b1;
    frame_q = '{enc(8'h00)};
    for (int i = 0; i < 256; i++) begin
      c = enc(8'($urandom_range(0, 255)));
      if (i % 17 == 0) c[i % 12] = ~c[i % 12];
      frame_q.push_back(c);
    end
    run_frame(1'b0, 16, 1'b0);
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset after two of three payload bytes.
    frame_q = '{enc(8'h03), enc(8'h11), enc(8'h22), enc(8'h33)};
    begin
      bit b, u;
      int cc;
      model_frame(b, cc, u);
    end
    send_cw(frame_q[0]);
    send_cw(frame_q[1]);
    send_cw(frame_q[2]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_bytes.delete(); exp_corr_q.delete(); exp_unc_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame_q = '{enc(8'h01), enc(8'h5A) ^ 12'h008};
    run_frame(1'b0, 1, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("leftover_bytes", exp_bytes.size(), 0);
    check("leftover_status", exp_corr_q.size(), 0);
    check("leftover_hdr_err", exp_hdr_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
